// File: rtl/ov7670_stream_gen.sv
// OV7670 parallel-bus transmitter model: pclk divider, VGA-style frame timing
// (vsync / back porch / active / front porch) and a built-in RGB565 pattern
// source, two bytes per pixel, most significant byte first.
module ov7670_stream_gen #(
    parameter int PCLK_DIV  = 2,
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 288,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int V_ACTIVE  = 480,
    parameter int VFP_LINES = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] colour_in,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int              DW        = $clog2(PCLK_DIV);
    localparam logic [DW-1:0]   DIV_LAST  = DW'(PCLK_DIV - 1);
    localparam logic [DW-1:0]   DIV_HALF  = DW'(PCLK_DIV / 2 - 1);
    localparam logic [15:0]     BYTE_LAST = 16'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0]     HREF_END  = 16'(2 * H_ACTIVE);
    localparam logic [15:0]     VS_LAST   = 16'(VS_LINES - 1);
    localparam logic [15:0]     VBP_LAST  = 16'(VBP_LINES - 1);
    localparam logic [15:0]     VA_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0]     VFP_LAST  = 16'(VFP_LINES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } state_t;

    logic [DW-1:0] div_q;
    logic          pclk_q;
    logic          tick;

    state_t        state_q, state_d;
    logic [15:0]   byte_q, byte_d;
    logic [15:0]   line_q, line_d;
    logic [15:0]   last_line;
    logic          end_frame;
    logic          start_frame;
    logic          href_d;
    logic [15:0]   pix_d;
    logic [7:0]    data_d;

    logic [1:0]    sel_q;
    logic [15:0]   colour_q;
    logic          vsync_q;
    logic          href_q;
    logic [7:0]    data_q;
    logic          done_q;
    logic [15:0]   frame_cnt_q;

    // Colour-bar lookup: bar index = x*8/H_ACTIVE resolved by a compare chain on x*8.
    function automatic logic [15:0] bar_colour(input logic [17:0] x8);
        if      (x8 < 18'(1 * H_ACTIVE)) return 16'hFFFF;
        else if (x8 < 18'(2 * H_ACTIVE)) return 16'hFFE0;
        else if (x8 < 18'(3 * H_ACTIVE)) return 16'h07FF;
        else if (x8 < 18'(4 * H_ACTIVE)) return 16'h07E0;
        else if (x8 < 18'(5 * H_ACTIVE)) return 16'hF81F;
        else if (x8 < 18'(6 * H_ACTIVE)) return 16'hF800;
        else if (x8 < 18'(7 * H_ACTIVE)) return 16'h001F;
        else                             return 16'h0000;
    endfunction

    // RGB565 value of pixel (x, y) for the selected pattern.
    function automatic logic [15:0] pattern_pix(input logic [1:0]  sel,
                                                input logic [15:0] colour,
                                                input logic [14:0] x,
                                                input logic [5:0]  y);
        case (sel)
            2'd0:    return bar_colour({x, 3'b000});
            2'd1:    return {x[4:0], y, x[4:0]};
            2'd2:    return (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
            default: return colour;
        endcase
    endfunction

    assign tick = (div_q == DIV_LAST);

    // pclk divider: rises mid-period, falls on the wrap, which is the output update tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_q  <= '0;
            pclk_q <= 1'b0;
        end else if (tick) begin
            div_q  <= '0;
            pclk_q <= 1'b0;
        end else begin
            div_q <= div_q + DW'(1);
            if (div_q == DIV_HALF) begin
                pclk_q <= 1'b1;
            end
        end
    end

    // Next frame position and the bus values that belong to it.
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        line_d    = line_q;
        end_frame = 1'b0;
        case (state_q)
            ST_VSYNC:  last_line = VS_LAST;
            ST_VBP:    last_line = VBP_LAST;
            ST_ACTIVE: last_line = VA_LAST;
            default:   last_line = VFP_LAST;
        endcase
        if (state_q == ST_IDLE) begin
            byte_d = 16'd0;
            line_d = 16'd0;
            if (enable) begin
                state_d = ST_VSYNC;
            end
        end else if (byte_q == BYTE_LAST) begin
            byte_d = 16'd0;
            if (line_q == last_line) begin
                line_d = 16'd0;
                case (state_q)
                    ST_VSYNC:  state_d = ST_VBP;
                    ST_VBP:    state_d = ST_ACTIVE;
                    ST_ACTIVE: state_d = ST_VFP;
                    default: begin
                        end_frame = 1'b1;
                        state_d   = enable ? ST_VSYNC : ST_IDLE;
                    end
                endcase
            end else begin
                line_d = line_q + 16'd1;
            end
        end else begin
            byte_d = byte_q + 16'd1;
        end
        start_frame = (state_d == ST_VSYNC) && ((state_q == ST_IDLE) || (state_q == ST_VFP));
        href_d      = (state_d == ST_ACTIVE) && (byte_d < HREF_END);
        pix_d       = pattern_pix(sel_q, colour_q, byte_d[15:1], line_d[5:0]);
        data_d      = href_d ? (byte_d[0] ? pix_d[7:0] : pix_d[15:8]) : 8'h00;
    end

    // Frame FSM and registered bus outputs, advanced once per pclk falling edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            byte_q      <= 16'd0;
            line_q      <= 16'd0;
            sel_q       <= 2'd0;
            colour_q    <= 16'd0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            done_q <= 1'b0;
            if (tick) begin
                state_q <= state_d;
                byte_q  <= byte_d;
                line_q  <= line_d;
                vsync_q <= (state_d == ST_VSYNC);
                href_q  <= href_d;
                data_q  <= data_d;
                if (start_frame) begin
                    sel_q    <= pattern_sel;
                    colour_q <= colour_in;
                end
                if (end_frame) begin
                    done_q      <= 1'b1;
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end
            end
        end
    end

    assign cam_pclk   = pclk_q;
    assign cam_vsync  = vsync_q;
    assign cam_href   = href_q;
    assign cam_data   = data_q;
    assign frame_done = done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: a small-timing instance checked every sys_clk
// against a frame-position model, plus a VGA-width instance whose colour bars
// are checked against hand-computed bytes.
module tb_ov7670_stream_gen;

    localparam int HA     = 4;
    localparam int HB     = 2;
    localparam int VS     = 1;
    localparam int VBP    = 1;
    localparam int VA     = 2;
    localparam int VFP    = 1;
    localparam int S_LINE = 2 * HA + HB;
    localparam int FRAME  = (VS + VBP + VA + VFP) * S_LINE;

    logic        sys_clk     = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        wr_n        = 1'b0;
    logic        enable      = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] colour_in   = 16'd0;

    logic        cam_pclk, cam_vsync, cam_href, frame_done;
    logic [7:0]  cam_data;
    logic [15:0] frame_cnt;

    logic        w_pclk, w_vs, w_hr, w_done;
    logic [7:0]  w_d;
    logic [15:0] w_fcnt;

    always #5 sys_clk = ~sys_clk;

    ov7670_stream_gen #(
        .PCLK_DIV(2), .H_ACTIVE(HA), .H_BLANK(HB), .VS_LINES(VS),
        .VBP_LINES(VBP), .V_ACTIVE(VA), .VFP_LINES(VFP)
    ) u_small (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
        .pattern_sel(pattern_sel), .colour_in(colour_in),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    ov7670_stream_gen #(
        .PCLK_DIV(2), .H_ACTIVE(640), .H_BLANK(288), .VS_LINES(1),
        .VBP_LINES(1), .V_ACTIVE(1), .VFP_LINES(1)
    ) u_wide (
        .sys_clk(sys_clk), .sys_rst_n(wr_n), .enable(1'b1),
        .pattern_sel(2'd0), .colour_in(16'h0000),
        .cam_pclk(w_pclk), .cam_vsync(w_vs), .cam_href(w_hr),
        .cam_data(w_d), .frame_done(w_done), .frame_cnt(w_fcnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit probe     = 1'b0;
    bit preload   = 1'b0;
    bit solid_lit = 1'b0;
    bit final_req = 1'b0;

    // model state
    int          k = 0;
    bit          m_run = 1'b0;
    int          m_t = 0;
    logic [1:0]  m_sel = 2'd0;
    logic [15:0] m_col = 16'd0;
    logic [15:0] m_frames = 16'd0;
    logic        m_hr = 1'b0;
    logic        e_vs;
    logic [7:0]  e_d;
    bit          e_done;
    bit          tick;

    // literal measurements
    bit vs_prev = 0, vs_valid = 0, hr_prev = 0, hr_valid = 0;
    bit first_done = 0, wrap_lit = 0, final_done = 0;
    int vs_run = 0, hr_run = 0, since_vs = 0;

    // wide instance tracking
    int         w_idx = 0, w_lines = 0, w_frames = 0;
    bit         w_prev = 0, w_has;
    logic [7:0] w_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pix_model(input logic [1:0] sel, input logic [15:0] col,
                                              input int x, input int y);
        int bar;
        case (sel)
            2'd0: begin
                bar = (x * 8) / HA;
                case (bar)
                    0:       return 16'hFFFF;
                    1:       return 16'hFFE0;
                    2:       return 16'h07FF;
                    3:       return 16'h07E0;
                    4:       return 16'hF81F;
                    5:       return 16'hF800;
                    6:       return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'd1:    return 16'(((x % 32) * 2048) + ((y % 64) * 32) + (x % 32));
            2'd2:    return (((x / 32) % 2) != ((y / 32) % 2)) ? 16'hFFFF : 16'h0000;
            default: return col;
        endcase
    endfunction

    task automatic model_out(input bit run, input int t, input logic [1:0] sel,
                             input logic [15:0] col, output logic vs, output logic hr,
                             output logic [7:0] d);
        int ln, b;
        logic [15:0] pix;
        vs = 1'b0;
        hr = 1'b0;
        d  = 8'h00;
        if (run) begin
            ln = t / S_LINE;
            b  = t % S_LINE;
            vs = (ln < VS);
            if (ln >= VS + VBP && ln < VS + VBP + VA && b < 2 * HA) begin
                hr  = 1'b1;
                pix = pix_model(sel, col, b / 2, ln - VS - VBP);
                d   = (b % 2 == 0) ? pix[15:8] : pix[7:0];
            end
        end
    endtask

    always begin
        @(negedge sys_clk or posedge probe);
        if (sys_clk == 1'b1) begin
            chk("rst_async", 32'({cam_pclk, cam_vsync, cam_href, cam_data, frame_done}), 32'd0);
        end else begin
            if (!sys_rst_n) begin
                k = 0; m_run = 0; m_t = 0; m_frames = 16'd0; m_hr = 1'b0;
                vs_prev = 0; vs_valid = 0; hr_prev = 0; hr_valid = 0;
                chk("reset_state",
                    32'({cam_pclk, cam_vsync, cam_href, cam_data, frame_done, frame_cnt}), 32'd0);
            end else begin
                k++;
                tick   = (k % 2 == 0);
                e_done = 1'b0;
                if (preload) begin
                    m_frames = 16'hFFFF;
                    wrap_lit = 1'b1;
                end
                if (tick) begin
                    if (!m_run) begin
                        if (enable) begin
                            m_run = 1'b1; m_t = 0; m_sel = pattern_sel; m_col = colour_in;
                        end
                    end else begin
                        m_t++;
                        if (m_t == FRAME) begin
                            e_done   = 1'b1;
                            m_frames = m_frames + 16'd1;
                            if (enable) begin
                                m_t = 0; m_sel = pattern_sel; m_col = colour_in;
                            end else begin
                                m_run = 1'b0; m_t = 0;
                            end
                        end
                    end
                end
                model_out(m_run, m_t, m_sel, m_col, e_vs, m_hr, e_d);
                chk("stream",
                    32'({cam_pclk, cam_vsync, cam_href, cam_data, frame_done, frame_cnt}),
                    32'({k[0], e_vs, m_hr, e_d, e_done, m_frames}));
                if (tick) begin
                    if (vs_valid) since_vs++;
                    if (frame_done && vs_valid) chk("frame_len", 32'(since_vs), 32'd50);
                    if (frame_done && !first_done) begin
                        chk("first_frame_cnt", 32'(frame_cnt), 32'd1);
                        first_done = 1'b1;
                    end
                    if (frame_done && wrap_lit) begin
                        chk("frame_cnt_wrap", 32'(frame_cnt), 32'h0000);
                        wrap_lit = 1'b0;
                    end
                    if (cam_vsync && !vs_prev) begin
                        vs_valid = 1'b1; since_vs = 0; vs_run = 0;
                    end
                    if (cam_vsync) vs_run++;
                    else if (vs_prev && vs_valid) chk("vsync_len", 32'(vs_run), 32'd10);
                    vs_prev = cam_vsync;
                    if (cam_href && !hr_prev) begin
                        hr_valid = 1'b1; hr_run = 0;
                    end
                    if (cam_href) begin
                        if (solid_lit) chk("solid_byte", 32'(cam_data), (hr_run % 2 == 1) ? 32'h1F : 32'hF8);
                        hr_run++;
                    end else if (hr_prev && hr_valid) begin
                        chk("href_len", 32'(hr_run), 32'd8);
                    end
                    hr_prev = cam_href;
                end
            end
            if (!wr_n) begin
                w_idx = 0; w_prev = 0;
            end else begin
                if (w_pclk && w_hr) begin
                    w_has = 1'b1;
                    case (w_idx)
                        0, 1, 159, 160:      w_exp = 8'hFF;
                        161:                 w_exp = 8'hE0;
                        640:                 w_exp = 8'hF8;
                        641:                 w_exp = 8'h1F;
                        959, 960:            w_exp = 8'h00;
                        961:                 w_exp = 8'h1F;
                        1120, 1121, 1279:    w_exp = 8'h00;
                        default: begin w_has = 1'b0; w_exp = 8'h00; end
                    endcase
                    if (w_has) chk("wide_bar", 32'(w_d), 32'(w_exp));
                    if (w_idx == 0) chk("wide_vsync_low", 32'(w_vs), 32'd0);
                    w_idx++;
                end
                if (!w_hr && w_prev) begin
                    chk("wide_line_len", 32'(w_idx), 32'd1280);
                    w_idx = 0;
                    w_lines++;
                end
                w_prev = w_hr;
                if (w_done) w_frames++;
            end
            if (final_req && !final_done) begin
                chk("wide_line_seen", 32'(w_lines >= 1), 32'd1);
                chk("wide_frame_cnt", 32'(w_fcnt), 32'(w_frames));
                final_done = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    initial begin
        // reset held, then idle with pclk running
        step(5);
        sys_rst_n = 1'b1;
        wr_n      = 1'b1;
        step(10);

        // solid F81F frame, colour change mid-frame, second frame then stop
        pattern_sel = 2'd3;
        colour_in   = 16'hF81F;
        solid_lit   = 1'b1;
        enable      = 1'b1;
        step(70);
        colour_in   = 16'h1234;
        step(22);
        solid_lit   = 1'b0;
        step(58);
        enable      = 1'b0;
        step(110);

        // randomized enable / pattern / colour
        for (int i = 0; i < 40; i++) begin
            enable      = ($urandom_range(0, 3) != 0);
            pattern_sel = 2'($urandom_range(0, 3));
            colour_in   = 16'($urandom);
            step(int'($urandom_range(1, 80)));
        end
        enable = 1'b0;
        step(120);

        // enable dropped during active line 1: frame completes, then idle
        pattern_sel = 2'd3;
        colour_in   = 16'hAAAA;
        enable      = 1'b1;
        for (int i = 0; i < 400 && !(m_run && m_t >= 3 * S_LINE); i++) @(negedge sys_clk);
        #1;
        enable    = 1'b0;
        colour_in = 16'h5555;
        step(150);

        // frame counter preloaded to FFFF wraps after one frame
        force u_small.frame_cnt_q = 16'hFFFF;
        preload = 1'b1;
        step(1);
        release u_small.frame_cnt_q;
        preload     = 1'b0;
        pattern_sel = 2'd1;
        enable      = 1'b1;
        step(10);
        enable = 1'b0;
        step(130);

        // asynchronous reset while href is high
        pattern_sel = 2'd2;
        enable      = 1'b1;
        for (int i = 0; i < 400 && !m_hr; i++) @(negedge sys_clk);
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 probe = 1'b1;
        step(1);
        probe  = 1'b0;
        enable = 1'b0;
        step(3);
        sys_rst_n = 1'b1;
        step(20);

        // let the wide instance finish its active line
        step(9000);
        final_req = 1'b1;
        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
